// File: rtl/iomem_fabric_pkg.sv
// iomem_fabric_pkg: shared FSM encoding and constants for the iomem bus fabric
package iomem_fabric_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  localparam logic [31:0] DEF_ERR_RDATA = 32'hDEAD_BEEF;
  localparam int ERR_CNT_W = 8;
endpackage

// File: rtl/iomem_fabric_decode.sv
// iomem_fabric_decode: base/mask address decode to a lowest-index-wins one-hot hit vector
module iomem_fabric_decode #(
  parameter int NUM_SLAVES = 4,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE = '0,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK = '0
) (
  input  logic [31:0]           i_addr,
  output logic [NUM_SLAVES-1:0] o_hit,
  output logic                  o_any_hit
);
  logic [NUM_SLAVES-1:0] w_raw;
  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_hit
    assign w_raw[i] = (i_addr & SLAVE_MASK[32*i+:32]) == SLAVE_BASE[32*i+:32];
  end
  assign o_hit = w_raw & (~w_raw + NUM_SLAVES'(1));
  assign o_any_hit = |w_raw;
endmodule

// File: rtl/iomem_fabric.sv
// iomem_fabric: table-decoded iomem fabric with registered slave handshake, timeout and sticky error capture
module iomem_fabric
  import iomem_fabric_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE = {32'h0600_0000, 32'h0500_0000, 32'h0400_0000, 32'h0300_0000},
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK = {NUM_SLAVES{32'hFF00_0000}},
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA = DEF_ERR_RDATA
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_mem_valid,
  output logic                    o_mem_ready,
  input  logic [31:0]             i_mem_addr,
  input  logic [31:0]             i_mem_wdata,
  input  logic [3:0]              i_mem_wstrb,
  output logic [31:0]             o_mem_rdata,
  output logic [NUM_SLAVES-1:0]   o_slv_valid,
  input  logic [NUM_SLAVES-1:0]   i_slv_ready,
  output logic [31:0]             o_slv_addr,
  output logic [31:0]             o_slv_wdata,
  output logic [3:0]              o_slv_wstrb,
  input  logic [32*NUM_SLAVES-1:0] i_slv_rdata,
  output logic                    o_err_irq,
  input  logic                    i_err_clear,
  output logic [31:0]             o_err_addr,
  output logic [ERR_CNT_W-1:0]    o_err_count
);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  state_t                r_state;
  logic [31:0]           r_timer;
  logic                  r_mem_ready;
  logic [31:0]           r_mem_rdata;
  logic [NUM_SLAVES-1:0] r_slv_valid;
  logic [31:0]           r_slv_addr;
  logic [31:0]           r_slv_wdata;
  logic [3:0]            r_slv_wstrb;
  logic                  r_err_irq;
  logic [31:0]           r_err_addr;
  logic [ERR_CNT_W-1:0]  r_err_count;
  logic [NUM_SLAVES-1:0] w_hit;
  logic                  w_any_hit;
  logic [31:0]           w_slv_rdata;
  logic                  w_done;
  logic                  w_timeout;
  logic                  w_err;
  logic [31:0]           w_err_addr;
  iomem_fabric_decode #(
    .NUM_SLAVES(NUM_SLAVES),
    .SLAVE_BASE(SLAVE_BASE),
    .SLAVE_MASK(SLAVE_MASK)
  ) u_decode (
    .i_addr(i_mem_addr),
    .o_hit(w_hit),
    .o_any_hit(w_any_hit)
  );
  always_comb begin
    w_slv_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      w_slv_rdata = w_slv_rdata | (r_slv_valid[i] ? i_slv_rdata[32*i+:32] : 32'h0);
  end
  assign w_done = |(r_slv_valid & i_slv_ready);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_timer == TO_LAST);
  assign w_err = (r_state == S_IDLE && i_mem_valid && !w_any_hit) ||
                 (r_state == S_ACCESS && !w_done && w_timeout);
  assign w_err_addr = r_state == S_IDLE ? i_mem_addr : r_slv_addr;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_mem_ready <= 1'b0;
      r_mem_rdata <= '0;
      r_slv_valid <= '0;
      r_slv_addr  <= '0;
      r_slv_wdata <= '0;
      r_slv_wstrb <= '0;
      r_err_irq   <= 1'b0;
      r_err_addr  <= '0;
      r_err_count <= '0;
    end else begin
      r_mem_ready <= 1'b0;
      if (w_err) begin
        r_err_irq   <= 1'b1;
        r_err_addr  <= w_err_addr;
        r_err_count <= r_err_count == '1 ? r_err_count : r_err_count + ERR_CNT_W'(1);
      end else if (i_err_clear) begin
        r_err_irq <= 1'b0;
      end
      case (r_state)
        S_IDLE: if (i_mem_valid) begin
          r_slv_addr  <= i_mem_addr;
          r_slv_wdata <= i_mem_wdata;
          r_slv_wstrb <= i_mem_wstrb;
          r_slv_valid <= w_hit;
          r_state     <= w_any_hit ? S_ACCESS : S_RESP;
          r_mem_ready <= !w_any_hit;
          r_mem_rdata <= w_any_hit ? r_mem_rdata : ERR_RDATA;
        end
        S_ACCESS: begin
          r_timer <= r_timer + 32'd1;
          if (w_done || w_timeout) begin
            r_slv_valid <= '0;
            r_state     <= S_RESP;
            r_mem_ready <= 1'b1;
            r_mem_rdata <= w_done ? w_slv_rdata : ERR_RDATA;
          end
        end
        default: begin
          r_timer <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
  assign o_mem_ready = r_mem_ready;
  assign o_mem_rdata = r_mem_rdata;
  assign o_slv_valid = r_slv_valid;
  assign o_slv_addr  = r_slv_addr;
  assign o_slv_wdata = r_slv_wdata;
  assign o_slv_wstrb = r_slv_wstrb;
  assign o_err_irq   = r_err_irq;
  assign o_err_addr  = r_err_addr;
  assign o_err_count = r_err_count;
endmodule

// File: tb/tb_iomem_fabric.sv
// tb_iomem_fabric: directed self-checking bench for iomem_fabric
module tb_iomem_fabric;
  logic         clk = 1'b0;
  logic         reset;
  logic         i_mem_valid;
  logic         o_mem_ready;
  logic [31:0]  i_mem_addr;
  logic [31:0]  i_mem_wdata;
  logic [3:0]   i_mem_wstrb;
  logic [31:0]  o_mem_rdata;
  logic [3:0]   o_slv_valid;
  logic [3:0]   i_slv_ready;
  logic [31:0]  o_slv_addr;
  logic [31:0]  o_slv_wdata;
  logic [3:0]   o_slv_wstrb;
  logic [127:0] i_slv_rdata;
  logic         o_err_irq;
  logic         i_err_clear;
  logic [31:0]  o_err_addr;
  logic [7:0]   o_err_count;
  int checks = 0;
  int errors = 0;
  iomem_fabric #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk),
    .reset(reset),
    .i_mem_valid(i_mem_valid),
    .o_mem_ready(o_mem_ready),
    .i_mem_addr(i_mem_addr),
    .i_mem_wdata(i_mem_wdata),
    .i_mem_wstrb(i_mem_wstrb),
    .o_mem_rdata(o_mem_rdata),
    .o_slv_valid(o_slv_valid),
    .i_slv_ready(i_slv_ready),
    .o_slv_addr(o_slv_addr),
    .o_slv_wdata(o_slv_wdata),
    .o_slv_wstrb(o_slv_wstrb),
    .i_slv_rdata(i_slv_rdata),
    .o_err_irq(o_err_irq),
    .i_err_clear(i_err_clear),
    .o_err_addr(o_err_addr),
    .o_err_count(o_err_count)
  );
  always #5 clk = ~clk;
  task test_reset;
    reset = 1'b1;
    i_mem_valid = 1'b0;
    i_mem_addr = '0;
    i_mem_wdata = '0;
    i_mem_wstrb = '0;
    i_slv_ready = '0;
    i_slv_rdata = '0;
    i_err_clear = 1'b0;
    #2;
    checks++;
    if ({o_mem_ready, o_mem_rdata, o_slv_valid, o_slv_addr, o_slv_wdata, o_slv_wstrb, o_err_irq, o_err_addr, o_err_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b rd=%h v=%b a=%h irq=%b ea=%h cnt=%0d exp all zero", o_mem_ready, o_mem_rdata, o_slv_valid, o_slv_addr, o_err_irq, o_err_addr, o_err_count);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask
  task test_read_hit;
    i_slv_ready = 4'b1111;
    i_slv_rdata = {32'h0, 32'h0, 32'h1234_5678, 32'h0};
    i_mem_valid = 1'b1;
    i_mem_addr = 32'h0400_0010;
    i_mem_wstrb = 4'b0000;
    @(posedge clk); #1;
    checks++;
    if (o_slv_valid !== 4'b0010) begin errors++; $display("FAIL rd_slv_valid got %b exp 0010", o_slv_valid); end
    checks++;
    if (o_mem_ready !== 1'b0) begin errors++; $display("FAIL rd_early_ready got %b exp 0", o_mem_ready); end
    checks++;
    if (o_slv_addr !== 32'h0400_0010) begin errors++; $display("FAIL rd_slv_addr got %h exp 04000010", o_slv_addr); end
    @(posedge clk); #1;
    checks++;
    if (o_mem_ready !== 1'b1 || o_mem_rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL rd_data got rdy=%b rd=%h exp rdy=1 rd=12345678", o_mem_ready, o_mem_rdata);
    end
    checks++;
    if (o_err_irq !== 1'b0 || o_slv_valid !== 4'b0000) begin
      errors++; $display("FAIL rd_irq_valid got irq=%b v=%b exp irq=0 v=0000", o_err_irq, o_slv_valid);
    end
    i_mem_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (o_mem_ready !== 1'b0) begin errors++; $display("FAIL rd_ready_pulse got %b exp 0", o_mem_ready); end
  endtask
  task test_write;
    int pulses;
    pulses = 0;
    i_slv_ready = 4'b0000;
    i_mem_valid = 1'b1;
    i_mem_addr = 32'h0300_0004;
    i_mem_wdata = 32'hCAFE_F00D;
    i_mem_wstrb = 4'b0011;
    @(posedge clk); #1;
    checks++;
    if (o_slv_valid !== 4'b0001 || o_slv_wstrb !== 4'b0011) begin
      errors++; $display("FAIL wr_start got v=%b strb=%b exp v=0001 strb=0011", o_slv_valid, o_slv_wstrb);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (o_slv_wdata !== 32'hCAFE_F00D || o_slv_valid !== 4'b0001 || o_mem_ready !== 1'b0) begin
        errors++; $display("FAIL wr_hold got wd=%h v=%b rdy=%b exp wd=cafef00d v=0001 rdy=0", o_slv_wdata, o_slv_valid, o_mem_ready);
      end
    end
    i_slv_ready = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (o_mem_ready) begin
        pulses++;
        i_mem_valid = 1'b0;
        i_slv_ready = 4'b0000;
      end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL wr_pulses got %0d exp 1", pulses); end
    i_mem_wstrb = 4'b0000;
  endtask
  task test_unmapped;
    i_mem_valid = 1'b1;
    i_mem_addr = 32'h0900_0000;
    @(posedge clk); #1;
    checks++;
    if (o_mem_ready !== 1'b1 || o_mem_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL um_resp got rdy=%b rd=%h exp rdy=1 rd=deadbeef", o_mem_ready, o_mem_rdata);
    end
    checks++;
    if (o_err_irq !== 1'b1 || o_err_addr !== 32'h0900_0000 || o_err_count !== 8'd1) begin
      errors++; $display("FAIL um_err got irq=%b ea=%h cnt=%0d exp irq=1 ea=09000000 cnt=1", o_err_irq, o_err_addr, o_err_count);
    end
    checks++;
    if (o_slv_valid !== 4'b0000) begin errors++; $display("FAIL um_slv_valid got %b exp 0000", o_slv_valid); end
    i_mem_valid = 1'b0;
    i_err_clear = 1'b1;
    @(posedge clk); #1;
    i_err_clear = 1'b0;
    checks++;
    if (o_err_irq !== 1'b0 || o_err_count !== 8'd1) begin
      errors++; $display("FAIL um_clear got irq=%b cnt=%0d exp irq=0 cnt=1", o_err_irq, o_err_count);
    end
  endtask
  task test_timeout;
    i_slv_ready = 4'b0000;
    i_slv_rdata = {32'h0, 32'h5555_AAAA, 64'h0};
    i_mem_valid = 1'b1;
    i_mem_addr = 32'h0500_0000;
    @(posedge clk); #1;
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (o_slv_valid !== 4'b0100 || o_mem_ready !== 1'b0) begin
        errors++; $display("FAIL to_wait cycle %0d got v=%b rdy=%b exp v=0100 rdy=0", k + 1, o_slv_valid, o_mem_ready);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (o_slv_valid !== 4'b0100) begin errors++; $display("FAIL to_cycle8 got v=%b exp 0100", o_slv_valid); end
    @(posedge clk); #1;
    checks++;
    if (o_slv_valid !== 4'b0000 || o_mem_ready !== 1'b1 || o_mem_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL to_resp got v=%b rdy=%b rd=%h exp v=0000 rdy=1 rd=deadbeef", o_slv_valid, o_mem_ready, o_mem_rdata);
    end
    checks++;
    if (o_err_count !== 8'd2 || o_err_irq !== 1'b1 || o_err_addr !== 32'h0500_0000) begin
      errors++; $display("FAIL to_err got cnt=%0d irq=%b ea=%h exp cnt=2 irq=1 ea=05000000", o_err_count, o_err_irq, o_err_addr);
    end
    i_mem_valid = 1'b0;
    @(posedge clk); #1;
    i_mem_valid = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
    end
    i_slv_ready = 4'b0100;
    @(posedge clk); #1;
    checks++;
    if (o_mem_ready !== 1'b1 || o_mem_rdata !== 32'h5555_AAAA || o_err_count !== 8'd2) begin
      errors++; $display("FAIL to_ready_wins got rdy=%b rd=%h cnt=%0d exp rdy=1 rd=5555aaaa cnt=2", o_mem_ready, o_mem_rdata, o_err_count);
    end
    i_mem_valid = 1'b0;
    i_slv_ready = 4'b0000;
    @(posedge clk); #1;
  endtask
  task test_err_clear_and_saturate;
    i_mem_valid = 1'b1;
    i_mem_addr = 32'h0900_0040;
    i_err_clear = 1'b1;
    @(posedge clk); #1;
    i_err_clear = 1'b0;
    i_mem_valid = 1'b0;
    checks++;
    if (o_err_irq !== 1'b1 || o_err_count !== 8'd3) begin
      errors++; $display("FAIL clr_set_wins got irq=%b cnt=%0d exp irq=1 cnt=3", o_err_irq, o_err_count);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 297; k++) begin
      i_mem_valid = 1'b1;
      i_mem_addr = 32'h0A00_0000 | (32'(k) << 2);
      @(posedge clk); #1;
      i_mem_valid = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (o_err_count !== 8'd255) begin errors++; $display("FAIL sat_count got %0d exp 255", o_err_count); end
    checks++;
    if (o_err_addr !== 32'h0A00_04A0) begin errors++; $display("FAIL sat_err_addr got %h exp 0a0004a0", o_err_addr); end
  endtask
  task test_reset_mid_access;
    i_slv_ready = 4'b0000;
    i_slv_rdata = {32'h7777_1111, 96'h0};
    i_mem_valid = 1'b1;
    i_mem_addr = 32'h0600_0008;
    @(posedge clk); #1;
    checks++;
    if (o_slv_valid !== 4'b1000) begin errors++; $display("FAIL rst_pre_valid got %b exp 1000", o_slv_valid); end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({o_mem_ready, o_mem_rdata, o_slv_valid, o_slv_addr, o_slv_wdata, o_slv_wstrb, o_err_irq, o_err_addr, o_err_count} !== '0) begin
      errors++; $display("FAIL rst_mid got rdy=%b rd=%h v=%b a=%h irq=%b ea=%h cnt=%0d exp all zero", o_mem_ready, o_mem_rdata, o_slv_valid, o_slv_addr, o_err_irq, o_err_addr, o_err_count);
    end
    i_mem_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    i_slv_ready = 4'b1000;
    i_mem_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (o_slv_valid !== 4'b1000) begin errors++; $display("FAIL rst_post_valid got %b exp 1000", o_slv_valid); end
    @(posedge clk); #1;
    checks++;
    if (o_mem_ready !== 1'b1 || o_mem_rdata !== 32'h7777_1111 || o_err_irq !== 1'b0) begin
      errors++; $display("FAIL rst_post_data got rdy=%b rd=%h irq=%b exp rdy=1 rd=77771111 irq=0", o_mem_ready, o_mem_rdata, o_err_irq);
    end
    i_mem_valid = 1'b0;
    @(posedge clk); #1;
  endtask
  initial begin
    test_reset;
    test_read_hit;
    test_write;
    test_unmapped;
    test_timeout;
    test_err_clear_and_saturate;
    test_reset_mid_access;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
